// File: rtl/load_store_unit.sv
// RV64 load/store unit between EX/MEM and a 64-bit data memory: sizes, aligns, extends loads and
// turns sub-doubleword stores into read-modify-write of the enclosing doubleword.
module load_store_unit #(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW_RD, STORE_WR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] mem_address_q, mem_address_d;
  logic [63:0] mem_write_data_q, mem_write_data_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_fault_q, resp_fault_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  logic        accept, bad_align, fault;
  logic [5:0]  shamt;
  logic [63:0] lane, lane_mask, merged;

  assign shamt = {off_q, 3'b000};
  assign lane  = mem_read_data >> shamt;

  always_comb begin
    lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    case (size_q)
      2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
      2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
      2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  end

  assign merged = (mem_read_data & ~(lane_mask << shamt)) | ((wdata_q & lane_mask) << shamt);

  always_comb begin
    bad_align = 1'b0;
    case (req_funct3[1:0])
      2'd1:    bad_align = req_addr[0];
      2'd2:    bad_align = (req_addr[1:0] != 2'd0);
      2'd3:    bad_align = (req_addr[2:0] != 3'd0);
      default: bad_align = 1'b0;
    endcase
  end

  // funct3=7 is only illegal for loads; a store uses just the size bits
  assign fault  = bad_align || (req_addr >= 64'(MEM_BYTES)) || (!req_write && req_funct3 == 3'd7);
  assign accept = req_valid && (state_q == IDLE) && (req_read || req_write);

  always_comb begin
    state_d          = state_q;
    off_d            = off_q;
    size_d           = size_q;
    uns_d            = uns_q;
    wdata_d          = wdata_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    resp_rdata_d     = 64'd0;
    resp_valid_d     = 1'b0;
    resp_fault_d     = 1'b0;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            off_d         = req_addr[2:0];
            size_d        = req_funct3[1:0];
            uns_d         = req_funct3[2];
            wdata_d       = req_wdata;
            mem_address_d = {req_addr[63:3], 3'b000};
            if (req_write && req_funct3[1:0] == 2'd3) begin
              state_d          = STORE_WR;
              mem_write_d      = 1'b1;
              mem_write_data_d = req_wdata;
            end else begin
              state_d    = req_write ? RMW_RD : LOAD;
              mem_read_d = 1'b1;
            end
          end
        end
      end
      LOAD: begin
        case (size_q)
          2'd0:    resp_rdata_d = {{56{~uns_q & lane[7]}},  lane[7:0]};
          2'd1:    resp_rdata_d = {{48{~uns_q & lane[15]}}, lane[15:0]};
          2'd2:    resp_rdata_d = {{32{~uns_q & lane[31]}}, lane[31:0]};
          default: resp_rdata_d = lane;
        endcase
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      RMW_RD: begin
        mem_write_data_d = merged;
        mem_write_d      = 1'b1;
        state_d          = STORE_WR;
      end
      STORE_WR: begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      off_q            <= 3'd0;
      size_q           <= 2'd0;
      uns_q            <= 1'b0;
      wdata_q          <= 64'd0;
      mem_address_q    <= 64'd0;
      mem_write_data_q <= 64'd0;
      resp_rdata_q     <= 64'd0;
      resp_valid_q     <= 1'b0;
      resp_fault_q     <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      off_q            <= off_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      wdata_q          <= wdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_valid_q     <= resp_valid_d;
      resp_fault_q     <= resp_fault_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
    end
  end

  // Gated by reset so a store caught mid-flight never reaches the memory edge
  assign req_ready      = (state_q == IDLE) & ~reset;
  assign resp_valid     = resp_valid_q & ~reset;
  assign resp_fault     = resp_fault_q & ~reset;
  assign resp_rdata     = resp_rdata_q & {64{~reset}};
  assign mem_read       = mem_read_q & ~reset;
  assign mem_write      = mem_write_q & ~reset;
  assign mem_address    = mem_address_q & {64{~reset}};
  assign mem_write_data = mem_write_data_q & {64{~reset}};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 2 KiB doubleword memory behind it.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_read, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault, mem_read, mem_write;
  logic [63:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem [0:255];
  logic        mem_init;
  int          rd_cnt = 0, wr_cnt = 0;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(2048)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_read(mem_read),
    .mem_write(mem_write), .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_address[10:3]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 64'd0;
      mem[1] <= 64'd20;
      mem[2] <= 64'd30;
      mem[6] <= 64'h1122_3344_5566_7788;
    end else if (mem_write) begin
      mem[mem_address[10:3]] <= mem_write_data;
    end
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] wd,
                       output int lat, output logic [63:0] rdata, output logic flt,
                       output int nrd, output int nwr);
    int rd0, wr0, n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout got=%b exp=1", req_ready);
    end
    rd0 = rd_cnt; wr0 = wr_cnt;
    req_valid = 1'b1; req_read = rd; req_write = wr; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; rdata = 'x; flt = 1'bx;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; flt = resp_fault;
        break;
      end
    end
    nrd = rd_cnt - rd0;
    nwr = wr_cnt - wr0;
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_funct3 = 3'd0; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_fault, mem_read, mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=00000",
                         {req_ready, resp_valid, resp_fault, mem_read, mem_write});
    end
    checks++;
    if (resp_rdata !== 64'd0 || mem_address !== 64'd0) begin
      errors++; $display("FAIL reset_data got=%h/%h exp=0/0", resp_rdata, mem_address);
    end
    @(posedge clk);
    #1 reset = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL ready_after_reset got=%b%b exp=10", req_ready, resp_valid);
    end
  endtask

  task automatic test_sign_extend;
    int lat, nr, nw; logic [63:0] d; logic f;
    issue(1'b0, 1'b1, 3'd3, 64'h28, 64'h80, lat, d, f, nr, nw);
    checks++;
    if (lat !== 2 || f !== 1'b0 || d !== 64'd0 || nw !== 1 || nr !== 0) begin
      errors++; $display("FAIL sd_resp got=lat%0d f%b d%h r%0d w%0d exp=lat2 f0 d0 r0 w1", lat, f, d, nr, nw);
    end
    issue(1'b1, 1'b0, 3'd0, 64'h28, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 2 || f !== 1'b0 || d !== 64'hFFFF_FFFF_FFFF_FF80 || nr !== 1) begin
      errors++; $display("FAIL lb got=lat%0d f%b d%h r%0d exp=lat2 f0 d=ffffffffffffff80 r1", lat, f, d, nr);
    end
    issue(1'b1, 1'b0, 3'd4, 64'h28, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 2 || d !== 64'h80) begin
      errors++; $display("FAIL lbu got=lat%0d d%h exp=lat2 d=80", lat, d);
    end
  endtask

  task automatic test_rmw;
    int lat, nr, nw; logic [63:0] d; logic f;
    issue(1'b0, 1'b1, 3'd0, 64'h0A, 64'hAB, lat, d, f, nr, nw);
    checks++;
    if (lat !== 3 || f !== 1'b0 || nr !== 1 || nw !== 1) begin
      errors++; $display("FAIL sb_rmw got=lat%0d f%b r%0d w%0d exp=lat3 f0 r1 w1", lat, f, nr, nw);
    end
    issue(1'b1, 1'b0, 3'd3, 64'h08, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 2 || d !== 64'h0000_0000_00AB_0014) begin
      errors++; $display("FAIL ld_after_sb got=lat%0d d%h exp=lat2 d=0000000000ab0014", lat, d);
    end
  endtask

  task automatic test_misaligned;
    int lat, nr, nw; logic [63:0] d; logic f;
    issue(1'b0, 1'b1, 3'd2, 64'h0D, 64'h1234, lat, d, f, nr, nw);
    checks++;
    if (lat !== 1 || f !== 1'b1 || d !== 64'd0 || nr !== 0 || nw !== 0) begin
      errors++; $display("FAIL sw_misaligned got=lat%0d f%b d%h r%0d w%0d exp=lat1 f1 d0 r0 w0", lat, f, d, nr, nw);
    end
    issue(1'b1, 1'b0, 3'd1, 64'h31, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 1 || f !== 1'b1 || nr !== 0) begin
      errors++; $display("FAIL lh_misaligned got=lat%0d f%b r%0d exp=lat1 f1 r0", lat, f, nr);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] rdy;
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'd1;
    req_addr = 64'h32; req_wdata = 64'h8001;
    @(posedge clk);
    #1 req_read = 1'b1; req_write = 1'b0; req_funct3 = 3'd2; req_addr = 64'h30;
    @(negedge clk); rdy[0] = req_ready;
    @(negedge clk); rdy[1] = req_ready;
    @(negedge clk); rdy[2] = req_ready;
    checks++;
    if (rdy !== 3'b100 || resp_valid !== 1'b1 || resp_fault !== 1'b0) begin
      errors++; $display("FAIL b2b_ready got=rdy%b v%b f%b exp=rdy100 v1 f0", rdy, resp_valid, resp_fault);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_lw_busy got=v%b r%b exp=v0 r0", resp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== 64'hFFFF_FFFF_8001_7788) begin
      errors++; $display("FAIL b2b_lw got=v%b d%h exp=v1 d=ffffffff80017788", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_lanes;
    int lat, nr, nw; logic [63:0] d; logic f;
    issue(1'b1, 1'b0, 3'd1, 64'h32, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (d !== 64'hFFFF_FFFF_FFFF_8001) begin
      errors++; $display("FAIL lh got=%h exp=ffffffffffff8001", d);
    end
    issue(1'b1, 1'b0, 3'd5, 64'h32, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (d !== 64'h8001) begin
      errors++; $display("FAIL lhu got=%h exp=8001", d);
    end
    issue(1'b1, 1'b0, 3'd6, 64'h30, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (d !== 64'h8001_7788) begin
      errors++; $display("FAIL lwu got=%h exp=80017788", d);
    end
    issue(1'b1, 1'b0, 3'd0, 64'h37, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (d !== 64'h11) begin
      errors++; $display("FAIL lb_top got=%h exp=11", d);
    end
  endtask

  task automatic test_illegal;
    int lat, nr, nw; logic [63:0] d; logic f; int seen;
    issue(1'b1, 1'b0, 3'd3, 64'h800, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 1 || f !== 1'b1 || d !== 64'd0 || nr !== 0 || nw !== 0) begin
      errors++; $display("FAIL ld_range got=lat%0d f%b d%h r%0d w%0d exp=lat1 f1 d0 r0 w0", lat, f, d, nr, nw);
    end
    issue(1'b1, 1'b0, 3'd7, 64'h10, 64'd0, lat, d, f, nr, nw);
    checks++;
    if (lat !== 1 || f !== 1'b1) begin
      errors++; $display("FAIL load_f3_7 got=lat%0d f%b exp=lat1 f1", lat, f);
    end
    @(negedge clk);
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || !req_ready) seen++;
    end
    req_valid = 1'b0;
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL no_op_request got=%0d exp=0", seen);
    end
  endtask

  task automatic test_reset_in_store;
    int seen, wr0;
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_funct3 = 3'd0;
    req_addr = 64'h10; req_wdata = 64'h5A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    #2;
    checks++;
    if (mem_write !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_store_wr got=w%b r%b exp=w0 r0", mem_write, req_ready);
    end
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
      if (k == 1) reset = 1'b0;
    end
    checks++;
    if (seen !== 0 || wr_cnt !== wr0) begin
      errors++; $display("FAIL reset_no_resp got=v%0d w%0d exp=v0 w0", seen, wr_cnt - wr0);
    end
    checks++;
    if (mem[2] !== 64'd30 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_word2 got=%h r%b exp=1e r1", mem[2], req_ready);
    end
  endtask

  initial begin
    test_reset();
    test_sign_extend();
    test_rmw();
    test_misaligned();
    test_back_to_back();
    test_lanes();
    test_illegal();
    test_reset_in_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
